irrigation_display_decoder: RTL and testbench

IRRIGATION_DISPLAY_DECODER -- requirements
Module: irrigation_display_decoder

---
 rtl/irrigation_display_decoder_pkg.sv | 78 +++++++
 rtl/irrigation_code_filter.sv | 54 +++++
 rtl/irrigation_display_decoder.sv | 114 +++++++++++
 tb/tb_irrigation_display_decoder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/irrigation_display_decoder_pkg.sv
// Shared mode codes, seven-segment glyphs and per-mode display text for the irrigation decoder.
package irrigation_display_decoder_pkg;

    localparam logic [1:0] MODE_OFF      = 2'd0;
    localparam logic [1:0] MODE_DRIPPER  = 2'd1;
    localparam logic [1:0] MODE_SPLINKER = 2'd2;
    localparam logic [1:0] MODE_FAULT    = 2'd3;

    localparam logic [2:0] CODE_OFF = 3'b000;

    // Active-low gfedcba
    localparam logic [6:0] GLYPH_O     = 7'b1000000;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_R     = 7'b0101111;
    localparam logic [6:0] GLYPH_I     = 7'b1111001;
    localparam logic [6:0] GLYPH_P     = 7'b0001100;
    localparam logic [6:0] GLYPH_S     = 7'b0010010;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Code bits are {irrigation_on, Bit1, Bit0}; Bit1 set while on means an encoder conflict.
    function automatic logic [1:0] code_to_mode(input logic [2:0] code);
        logic [1:0] m;
        if (!code[2]) begin
            m = MODE_OFF;
        end else if (code[1]) begin
            m = MODE_FAULT;
        end else if (code[0]) begin
            m = MODE_SPLINKER;
        end else begin
            m = MODE_DRIPPER;
        end
        return m;
    endfunction

    // Digit index 0 is the leftmost character.
    function automatic logic [6:0] text_glyph(input logic [1:0] m, input logic [1:0] idx);
        logic [6:0] g;
        g = GLYPH_BLANK;
        case (m)
            MODE_OFF: begin
                case (idx)
                    2'd0:    g = GLYPH_O;
                    2'd1:    g = GLYPH_F;
                    2'd2:    g = GLYPH_F;
                    default: g = GLYPH_BLANK;
                endcase
            end
            MODE_DRIPPER: begin
                case (idx)
                    2'd0:    g = GLYPH_D;
                    2'd1:    g = GLYPH_R;
                    2'd2:    g = GLYPH_I;
                    default: g = GLYPH_P;
                endcase
            end
            MODE_SPLINKER: begin
                case (idx)
                    2'd0:    g = GLYPH_S;
                    2'd1:    g = GLYPH_P;
                    2'd2:    g = GLYPH_R;
                    default: g = GLYPH_BLANK;
                endcase
            end
            default: begin
                case (idx)
                    2'd0:    g = GLYPH_E;
                    2'd1:    g = GLYPH_R;
                    2'd2:    g = GLYPH_R;
                    default: g = GLYPH_BLANK;
                endcase
            end
        endcase
        return g;
    endfunction

endpackage

// File: rtl/irrigation_code_filter.sv
// Stability filter: a code must be sampled STABLE_CYCLES times in a row before its mode is accepted.
module irrigation_code_filter
    import irrigation_display_decoder_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_code,
    output logic [1:0] o_mode,
    output logic       o_mode_changed
);

    // r_cnt holds (samples of candidate - 1), so acceptance is at STABLE_CYCLES-2.
    localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYCLES - 2);

    logic [2:0] r_cand;
    logic [7:0] r_cnt;
    logic [1:0] r_mode;
    logic       r_mode_changed;

    logic       w_same;
    logic       w_stable;
    logic [1:0] w_cand_mode;

    assign w_same      = (i_code == r_cand);
    assign w_stable    = w_same && (r_cnt >= ACCEPT_CNT);
    assign w_cand_mode = code_to_mode(r_cand);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand         <= CODE_OFF;
            r_cnt          <= 8'd0;
            r_mode         <= MODE_OFF;
            r_mode_changed <= 1'b0;
        end else begin
            r_mode_changed <= 1'b0;
            if (!w_same) begin
                r_cand <= i_code;
                r_cnt  <= 8'd0;
            end else if (r_cnt != 8'hFF) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_stable && (w_cand_mode != r_mode)) begin
                r_mode         <= w_cand_mode;
                r_mode_changed <= 1'b1;
            end
        end
    end

    assign o_mode         = r_mode;
    assign o_mode_changed = r_mode_changed;

endmodule

// File: rtl/irrigation_display_decoder.sv
// Irrigation status decoder: synchronises and filters the encoder code, then drives a
// four-digit multiplexed seven-segment display with a blinking fault indication.
module irrigation_display_decoder
    import irrigation_display_decoder_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned SCAN_DIV      = 4,
    parameter int unsigned BLINK_DIV     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       irrigation_on,
    input  logic       irrigation_encoded_Bit1,
    input  logic       irrigation_encoded_Bit0,
    output logic [1:0] mode,
    output logic       mode_changed,
    output logic [6:0] segments,
    output logic [3:0] digit_sel
);

    localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [23:0] BLINK_LAST = 24'(BLINK_DIV - 1);

    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [15:0] r_scan_cnt;
    logic [1:0]  r_digit_idx;
    logic [23:0] r_blink_cnt;
    logic        r_blink_on;
    logic [6:0]  r_segments;
    logic [3:0]  r_digit_sel;

    logic [1:0]  w_mode;
    logic        w_mode_changed;
    logic        w_fault;
    logic [6:0]  w_seg_next;
    logic [3:0]  w_dsel_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= CODE_OFF;
            r_sync2 <= CODE_OFF;
        end else begin
            r_sync1 <= {irrigation_on, irrigation_encoded_Bit1, irrigation_encoded_Bit0};
            r_sync2 <= r_sync1;
        end
    end

    irrigation_code_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_code         (r_sync2),
        .o_mode         (w_mode),
        .o_mode_changed (w_mode_changed)
    );

    // Scan runs freely across mode changes so the digit cadence never jumps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= 16'd0;
            r_digit_idx <= 2'd0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt  <= 16'd0;
            r_digit_idx <= r_digit_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 16'd1;
        end
    end

    assign w_fault = (w_mode == MODE_FAULT);

    // Held in reset outside FAULT so every entry starts in the visible phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= 24'd0;
            r_blink_on  <= 1'b1;
        end else if (!w_fault) begin
            r_blink_cnt <= 24'd0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= 24'd0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 24'd1;
        end
    end

    always_comb begin
        w_seg_next  = text_glyph(w_mode, r_digit_idx);
        w_dsel_next = ~(4'b1000 >> r_digit_idx);
        if (w_fault && !r_blink_on) begin
            w_seg_next  = GLYPH_BLANK;
            w_dsel_next = 4'b1111;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segments  <= GLYPH_BLANK;
            r_digit_sel <= 4'b1111;
        end else begin
            r_segments  <= w_seg_next;
            r_digit_sel <= w_dsel_next;
        end
    end

    assign mode         = w_mode;
    assign mode_changed = w_mode_changed;
    assign segments     = r_segments;
    assign digit_sel    = r_digit_sel;

endmodule

// File: tb/tb_irrigation_display_decoder.sv
// Scoreboard bench: a history-window reference model predicts mode changes and display text.
module tb_irrigation_display_decoder;

    localparam int unsigned STABLE = 4;
    localparam int unsigned SCAN   = 4;
    localparam int unsigned BLINK  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       on_in = 1'b0;
    logic       b1_in = 1'b0;
    logic       b0_in = 1'b0;
    logic [1:0] mode;
    logic       mode_changed;
    logic [6:0] segments;
    logic [3:0] digit_sel;

    always #5 clk = ~clk;

    irrigation_display_decoder #(
        .STABLE_CYCLES (STABLE),
        .SCAN_DIV      (SCAN),
        .BLINK_DIV     (BLINK)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .irrigation_on           (on_in),
        .irrigation_encoded_Bit1 (b1_in),
        .irrigation_encoded_Bit0 (b0_in),
        .mode                    (mode),
        .mode_changed            (mode_changed),
        .segments                (segments),
        .digit_sel               (digit_sel)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] exp_q[$];
    logic [2:0] hist[$];
    logic [1:0] m_mode;
    int         t_edge;
    int         fault_entry;
    logic [6:0] exp_seg;
    logic [3:0] exp_dsel;
    logic       model_valid = 1'b0;
    string      txt;
    int         didx;
    logic       stable_run;
    logic [1:0] new_mode;

    function automatic logic [6:0] glyph_of(input byte c);
        case (c)
            "O":     return 7'b1000000;
            "F":     return 7'b0001110;
            "d":     return 7'b0100001;
            "r":     return 7'b0101111;
            "I":     return 7'b1111001;
            "P":     return 7'b0001100;
            "S":     return 7'b0010010;
            "E":     return 7'b0000110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [1:0] mode_of(input logic [2:0] c);
        if (c[2] == 1'b0) return 2'd0;
        if (c == 3'b100)  return 2'd1;
        if (c == 3'b101)  return 2'd2;
        return 2'd3;
    endfunction

    function automatic string text_of(input logic [1:0] m);
        case (m)
            2'd0:    return "OFF ";
            2'd1:    return "drIP";
            2'd2:    return "SPr ";
            default: return "Err ";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: output at edge t shows digit ((t-1)/SCAN)%4 of the previously accepted
    // text; a code is accepted once the 2-edge-delayed input held it for STABLE edges.
    always @(posedge clk) begin
        if (!rst_n) begin
            hist.delete();
            for (int k = 0; k < int'(STABLE) + 2; k++) hist.push_back(3'b000);
            exp_q.delete();
            m_mode      = 2'd0;
            t_edge      = 0;
            fault_entry = 0;
            model_valid = 1'b0;
        end else begin
            t_edge++;
            didx = ((t_edge - 1) / int'(SCAN)) % 4;
            txt  = text_of(m_mode);
            exp_seg  = glyph_of(txt[didx]);
            exp_dsel = 4'b1111;
            exp_dsel[3 - didx] = 1'b0;
            if (m_mode == 2'd3 && (((t_edge - 1 - fault_entry) / int'(BLINK)) % 2 == 1)) begin
                exp_seg  = 7'b1111111;
                exp_dsel = 4'b1111;
            end
            hist.push_front({on_in, b1_in, b0_in});
            void'(hist.pop_back());
            stable_run = 1'b1;
            for (int k = 2; k < int'(STABLE) + 2; k++) begin
                if (hist[k] != hist[2]) stable_run = 1'b0;
            end
            new_mode = mode_of(hist[2]);
            if (stable_run && new_mode != m_mode) begin
                m_mode = new_mode;
                exp_q.push_back(new_mode);
                if (new_mode == 2'd3) fault_entry = t_edge;
            end
            model_valid = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_mode", 32'(mode), 32'd0);
            check("reset_pulse", 32'(mode_changed), 32'd0);
            check("reset_seg", 32'(segments), 32'h7f);
            check("reset_dsel", 32'(digit_sel), 32'hf);
        end else if (model_valid) begin
            check("mode", 32'(mode), 32'(m_mode));
            if (mode_changed) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_pulse: got mode_changed=1 expected 0 at %0t", $time);
                end else begin
                    check("pulse_mode", 32'(mode), 32'(exp_q.pop_front()));
                end
            end else if (exp_q.size() != 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL missing_pulse: got mode_changed=0 expected 1 at %0t", $time);
                void'(exp_q.pop_front());
            end
            check("segments", 32'(segments), 32'(exp_seg));
            check("digit_sel", 32'(digit_sel), 32'(exp_dsel));
        end
    end

    task automatic drive(input logic [2:0] code, input int cycles);
        {on_in, b1_in, b0_in} = code;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(3'b000, 5);
        drive(3'b101, 12);
        drive(3'b000, 12);
        drive(3'b101, 3);
        drive(3'b000, 10);
        drive(3'b011, 12);
        drive(3'b110, 40);
        drive(3'b100, 12);
        drive(3'b111, 30);
        repeat (150) drive(3'($urandom % 8), int'($urandom_range(1, STABLE + 3)));
        drive(3'b000, 10);
        drive(3'b101, 10);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        check("pre_reset_mode", 32'(mode), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_mode", 32'(mode), 32'd0);
        check("async_reset_seg", 32'(segments), 32'h7f);
        check("async_reset_dsel", 32'(digit_sel), 32'hf);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(3'b101, 10);
        repeat (60) drive(3'($urandom % 8), int'($urandom_range(1, STABLE + 3)));
        drive(3'b000, 12);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
